// File: rtl/poly_song_sequencer_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | poly_song_sequencer_pkg                                              |
// | Shared state encoding, default widths and song-ROM field layout      |
// | for the polyphonic song sequencer.                                   |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
package poly_song_sequencer_pkg;

  localparam int c_def_num_voices  = 3;
  localparam int c_def_note_w      = 6;
  localparam int c_def_dur_w       = 6;
  localparam int c_def_song_sel_w  = 2;
  localparam int c_def_note_addr_w = 5;

  typedef enum logic [2:0] {
    S_PAUSED    = 3'd0,
    S_FETCH     = 3'd1,
    S_DECODE    = 3'd2,
    S_DISPATCH  = 3'd3,
    S_ADVANCE   = 3'd4,
    S_INCREMENT = 3'd5
  } seq_state_e;

  // ROM word is {is_adv, note, dur}: is_adv sits in the MSB.
  function automatic int rom_adv_bit(input int note_w, input int dur_w);
    return note_w + dur_w;
  endfunction

  // The note field starts directly above the duration field.
  function automatic int rom_note_lsb(input int dur_w);
    return dur_w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/poly_song_sequencer_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | poly_song_sequencer_if                                               |
// | Song-ROM read bus and voice-bank dispatch bus of the sequencer.      |
// | master = sequencer side, slave = ROM / voice bank side.              |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
interface poly_song_sequencer_if
  import poly_song_sequencer_pkg::*;
#(
  parameter int NUM_VOICES  = c_def_num_voices,
  parameter int NOTE_W      = c_def_note_w,
  parameter int DUR_W       = c_def_dur_w,
  parameter int SONG_SEL_W  = c_def_song_sel_w,
  parameter int NOTE_ADDR_W = c_def_note_addr_w
);

  logic [SONG_SEL_W+NOTE_ADDR_W-1:0] rom_addr;
  logic [NOTE_W+DUR_W:0]             rom_data;
  logic [NUM_VOICES-1:0]             voice_free;
  logic [NUM_VOICES-1:0]             new_note;
  logic [NOTE_W-1:0]                 note_out;
  logic [DUR_W-1:0]                  dur_out;

  modport master (
    output rom_addr, new_note, note_out, dur_out,
    input  rom_data, voice_free
  );

  modport slave (
    input  rom_addr, new_note, note_out, dur_out,
    output rom_data, voice_free
  );

endinterface
`default_nettype wire

// File: rtl/poly_song_sequencer_beat_countdown.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | poly_song_sequencer_beat_countdown                                   |
// | Loadable beat down-counter used for time-advance events. A load      |
// | wins over a same-cycle beat; hold freezes the count.                 |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module poly_song_sequencer_beat_countdown #(
  parameter int DUR_W = 6
) (
  input  wire logic             clk,
  input  wire logic             rst,
  input  wire logic             i_load,
  input  wire logic [DUR_W-1:0] i_value,
  input  wire logic             i_beat,
  input  wire logic             i_hold,
  output logic                  o_zero
);

  logic [DUR_W-1:0] r_cnt;

  // Load the advance length, otherwise count beats down to zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_value;
    end else if (i_beat && !i_hold && (r_cnt != '0)) begin
      r_cnt <= r_cnt - DUR_W'(1);
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule
`default_nettype wire

// File: rtl/poly_song_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | poly_song_sequencer                                                  |
// | Walks a song ROM of note / time-advance words, dispatching notes to  |
// | the lowest-index free voice and blocking on advance events for a     |
// | counted number of beats.                                             |
// | Optional: POLY_VOICE_STEAL_EN - with no free voice, steal a voice    |
// | round-robin instead of stalling.                                     |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module poly_song_sequencer
  import poly_song_sequencer_pkg::*;
#(
  parameter int NUM_VOICES  = c_def_num_voices,
  parameter int NOTE_W      = c_def_note_w,
  parameter int DUR_W       = c_def_dur_w,
  parameter int SONG_SEL_W  = c_def_song_sel_w,
  parameter int NOTE_ADDR_W = c_def_note_addr_w
) (
  input  wire logic                  clk,
  input  wire logic                  reset,
  input  wire logic                  play,
  input  wire logic [SONG_SEL_W-1:0] song,
  input  wire logic                  beat,
  output logic                       song_done,
  output logic                       busy,
  poly_song_sequencer_if.master      bus
);

  localparam int c_adv_bit  = rom_adv_bit(NOTE_W, DUR_W);
  localparam int c_note_lsb = rom_note_lsb(DUR_W);

  seq_state_e              r_state;
  logic [SONG_SEL_W-1:0]   r_song_q;
  logic [NOTE_ADDR_W-1:0]  r_note_idx;
  logic                    r_resume_adv;
  logic                    r_song_done;
  logic [NOTE_W-1:0]       r_note;
  logic [DUR_W-1:0]        r_dur;

  logic                    w_rom_is_adv;
  logic [NOTE_W-1:0]       w_rom_note;
  logic [DUR_W-1:0]        w_rom_dur;
  logic [NOTE_ADDR_W:0]    w_inc;
  logic                    w_song_chg;
  logic                    w_adv_zero;
  logic                    w_dispatch;
  logic [NUM_VOICES-1:0]   w_strobe;

  // Lowest set bit of the free mask, as a one-hot vector.
  function automatic logic [NUM_VOICES-1:0] lowest_free(input logic [NUM_VOICES-1:0] v);
    logic [NUM_VOICES-1:0] w_sel;
    w_sel = '0;
    for (int i = NUM_VOICES - 1; i >= 0; i--) begin
      if (v[i]) begin
        w_sel    = '0;
        w_sel[i] = 1'b1;
      end
    end
    return w_sel;
  endfunction

  assign w_rom_is_adv = bus.rom_data[c_adv_bit];
  assign w_rom_note   = bus.rom_data[c_note_lsb +: NOTE_W];
  assign w_rom_dur    = bus.rom_data[DUR_W-1:0];
  assign w_inc        = {1'b0, r_note_idx} + (NOTE_ADDR_W+1)'(1);
  assign w_song_chg   = (song != r_song_q);
  assign w_dispatch   = (r_state == S_DISPATCH) && play;

`ifdef POLY_VOICE_STEAL_EN
  localparam int c_ptr_w = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;

  logic [c_ptr_w-1:0]    r_steal_ptr;
  logic [NUM_VOICES-1:0] w_steal_1h;
  logic                  w_steal;

  assign w_steal = w_dispatch && (bus.voice_free == '0);

  // Victim voice as a one-hot vector.
  always_comb begin
    w_steal_1h              = '0;
    w_steal_1h[r_steal_ptr] = 1'b1;
  end

  // Round-robin victim pointer, moves on after every steal.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_steal_ptr <= '0;
    end else if (w_steal) begin
      r_steal_ptr <= (r_steal_ptr == c_ptr_w'(NUM_VOICES - 1)) ? '0 : r_steal_ptr + c_ptr_w'(1);
    end
  end

  assign w_strobe = !w_dispatch ? '0 : (w_steal ? w_steal_1h : lowest_free(bus.voice_free));
`else
  assign w_strobe = w_dispatch ? lowest_free(bus.voice_free) : '0;
`endif

  poly_song_sequencer_beat_countdown #(
    .DUR_W (DUR_W)
  ) u_countdown (
    .clk     (clk),
    .rst     (reset),
    .i_load  ((r_state == S_DECODE) && w_rom_is_adv),
    .i_value (w_rom_dur),
    .i_beat  (beat),
    .i_hold  ((r_state != S_ADVANCE) || !play),
    .o_zero  (w_adv_zero)
  );

  // Sequencing FSM with registered note, duration and end-of-song pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_PAUSED;
      r_song_q     <= '0;
      r_note_idx   <= '0;
      r_resume_adv <= 1'b0;
      r_song_done  <= 1'b0;
      r_note       <= '0;
      r_dur        <= '0;
    end else begin
      r_song_done <= 1'b0;
      case (r_state)
        S_PAUSED: begin
          r_song_q <= song;
          // A new song restarts from its first entry and forgets any
          // interrupted advance.
          if (w_song_chg) begin
            r_note_idx   <= '0;
            r_resume_adv <= 1'b0;
          end
          if (play) begin
            r_state <= (r_resume_adv && !w_song_chg) ? S_ADVANCE : S_FETCH;
          end
        end
        S_FETCH: begin
          r_state <= play ? S_DECODE : S_PAUSED;
        end
        S_DECODE: begin
          if (w_rom_is_adv) begin
            r_state <= S_ADVANCE;
          end else begin
            r_note  <= w_rom_note;
            r_dur   <= w_rom_dur;
            r_state <= S_DISPATCH;
          end
        end
        S_DISPATCH: begin
          if (!play) begin
            r_state <= S_PAUSED;
          end else if (w_strobe != '0) begin
            r_state <= S_INCREMENT;
          end
        end
        S_ADVANCE: begin
          if (!play) begin
            r_resume_adv <= 1'b1;
            r_state      <= S_PAUSED;
          end else if (w_adv_zero) begin
            r_state <= S_INCREMENT;
          end
        end
        S_INCREMENT: begin
          r_resume_adv <= 1'b0;
          if (w_inc[NOTE_ADDR_W]) begin
            r_note_idx  <= '0;
            r_song_done <= 1'b1;
            r_state     <= S_PAUSED;
          end else begin
            r_note_idx <= w_inc[NOTE_ADDR_W-1:0];
            r_state    <= play ? S_FETCH : S_PAUSED;
          end
        end
        default: begin
          r_state <= S_PAUSED;
        end
      endcase
    end
  end

  assign bus.rom_addr = {r_song_q, r_note_idx};
  assign bus.new_note = w_strobe;
  assign bus.note_out = r_note;
  assign bus.dur_out  = r_dur;
  assign song_done    = r_song_done;
  assign busy         = (r_state != S_PAUSED);

endmodule
`default_nettype wire
